// File: rtl/vga_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : vga_rd_sched
// Description : DDR3 read scheduler for the VGA display path. Detects the
//               start of each display frame from vsync, flushes the pixel
//               FIFO, selects the newest completely written frame buffer
//               (ping-pong) and issues fixed-length read bursts whenever the
//               pixel FIFO has room, until the whole frame is requested.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rd_sched #(
    parameter logic [29:0] FB_BASE0    = 30'h0000000,
    parameter logic [29:0] FB_BASE1    = 30'h0800000,
    parameter logic [31:0] FRAME_BYTES = 32'd4915200,
    parameter int          BEAT_BYTES  = 16,
    parameter int          BURST_BEATS = 128,
    parameter int          FLUSH_CYC   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        wr_frame_done,
    input  logic        wr_buf,
    input  logic [11:0] fifo_space,
    output logic        rd_req,
    output logic [29:0] rd_addr,
    output logic [7:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_done,
    output logic        fifo_flush,
    output logic        rd_buf,
    output logic        busy,
    output logic [15:0] frame_drop_cnt
);

    localparam int              C_BURST_BYTES   = BURST_BEATS * BEAT_BYTES;
    localparam int              C_NBURST        = int'(FRAME_BYTES / 32'(C_BURST_BYTES));
    localparam logic [11:0]     C_NBURST_W      = 12'(C_NBURST);
    localparam logic [29:0]     C_BURST_BYTES_W = 30'(C_BURST_BYTES);
    localparam logic [12:0]     C_BURST_BEATS_W = 13'(BURST_BEATS);
    localparam int              C_FCNT_W        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [C_FCNT_W-1:0] C_FLUSH_LAST = C_FCNT_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_CHECK = 3'd2,
        S_REQ   = 3'd3,
        S_BUSY  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_vs_meta;
    logic                r_vs_sync;
    logic                r_vs_prev;
    logic                w_vs_rise;

    logic [C_FCNT_W-1:0] r_flush_cnt;
    logic [11:0]         r_bidx;
    logic                r_new_flag;
    logic                r_new_buf;
    logic                r_pend_abort;

    logic                r_rd_req;
    logic [29:0]         r_rd_addr;
    logic                r_fifo_flush;
    logic                r_rd_buf;
    logic                r_busy;
    logic [15:0]         r_drop_cnt;

    logic                w_drop_inc;
    logic                w_pend_set;
    logic                w_bidx_inc;
    logic                w_flush_entry;
    logic                w_req_entry;
    logic                w_space_ok;
    logic [29:0]         w_base;

    assign w_vs_rise     = r_vs_sync & ~r_vs_prev;
    assign w_flush_entry = (r_state != S_FLUSH) && (w_next == S_FLUSH);
    assign w_req_entry   = (r_state != S_REQ) && (w_next == S_REQ);
    assign w_space_ok    = ({1'b0, fifo_space} >= C_BURST_BEATS_W);
    assign w_base        = r_rd_buf ? FB_BASE1 : FB_BASE0;

    // Bring vsync into the clk domain and keep one extra stage for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= vsync_in;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus the per-cycle strobes that side registers act on
    always_comb begin
        w_next     = r_state;
        w_drop_inc = 1'b0;
        w_pend_set = 1'b0;
        w_bidx_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_vs_rise) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // vsync edges here belong to the frame just started
                if (r_flush_cnt == C_FLUSH_LAST) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_bidx == C_NBURST_W) begin
                    // Frame fully requested: a new vsync is not a drop
                    w_next = w_vs_rise ? S_FLUSH : S_DONE;
                end else if (w_vs_rise) begin
                    w_next     = S_FLUSH;
                    w_drop_inc = 1'b1;
                end else if (w_space_ok) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    // Accepted burst cannot be withdrawn; abort after it lands
                    w_next     = S_BUSY;
                    w_bidx_inc = 1'b1;
                    if (w_vs_rise) begin
                        w_pend_set = 1'b1;
                        w_drop_inc = 1'b1;
                    end
                end else if (w_vs_rise) begin
                    w_next     = S_FLUSH;
                    w_drop_inc = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_vs_rise && !r_pend_abort) begin
                    w_pend_set = 1'b1;
                    w_drop_inc = 1'b1;
                end
                if (rd_done) begin
                    w_next = (r_pend_abort || w_vs_rise) ? S_FLUSH : S_CHECK;
                end
            end
            S_DONE: begin
                if (w_vs_rise) begin
                    w_next = S_FLUSH;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Flush duration counter, restarted on every FLUSH entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
        end else if (w_flush_entry) begin
            r_flush_cnt <= '0;
        end else if (r_state == S_FLUSH) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Burst index within the current frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bidx <= '0;
        end else if (w_flush_entry) begin
            r_bidx <= '0;
        end else if (w_bidx_inc) begin
            r_bidx <= r_bidx + 12'd1;
        end
    end

    // Newest-written-buffer tracking; a same-cycle write completion re-arms the flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_new_flag <= 1'b0;
            r_new_buf  <= 1'b0;
            r_rd_buf   <= 1'b0;
        end else begin
            if (w_flush_entry && r_new_flag) begin
                r_rd_buf   <= r_new_buf;
                r_new_flag <= 1'b0;
            end
            if (wr_frame_done) begin
                r_new_flag <= 1'b1;
                r_new_buf  <= wr_buf;
            end
        end
    end

    // Deferred abort for a vsync that arrives while a burst is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_abort <= 1'b0;
        end else if (w_flush_entry) begin
            r_pend_abort <= 1'b0;
        end else if (w_pend_set) begin
            r_pend_abort <= 1'b1;
        end
    end

    // Saturating count of frames abandoned before all bursts were requested
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Registered outputs derived from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_req     <= 1'b0;
            r_fifo_flush <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rd_req     <= (w_next == S_REQ);
            r_fifo_flush <= (w_next == S_FLUSH);
            r_busy       <= (w_next != S_IDLE) && (w_next != S_DONE);
        end
    end

    // Burst address is loaded once on REQ entry and held until the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= '0;
        end else if (w_req_entry) begin
            r_rd_addr <= w_base + (30'(r_bidx) * C_BURST_BYTES_W);
        end
    end

    assign rd_req         = r_rd_req;
    assign rd_addr        = r_rd_addr;
    assign rd_len         = 8'(BURST_BEATS - 1);
    assign fifo_flush     = r_fifo_flush;
    assign rd_buf         = r_rd_buf;
    assign busy           = r_busy;
    assign frame_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
